ifmap_window_buffer: RTL

Clocked ifmap storage and window-scan stage. It sits directly downstream of the instruction decoder's ifmap-data output and accepts the decoder's ifmap write packets (`{done, filter_size, ifmap_data, ifmap_size, timestep}`). Incoming 36-pixel spike chunks are stored in a per-timestep bank. When a chunk flagged `done` arrives, the block scans that bank and emits one K×K convolution window per output location to the PE-side packetizer.

---
 rtl/ifmap_window_buffer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ifmap_window_buffer.sv
// ifmap_window_buffer
//   Stores 36-pixel ifmap spike chunks into a per-timestep bank. When a chunk
//   flagged done arrives, the block scans that bank and emits one KxK window
//   per output location, in row-major order with x as the inner loop.
//
//   Ports:
//     clk, rst      clock (rising edge), synchronous active-high reset
//     in_valid/in_ready/in_data   decoder write packet
//                                 {done, K[1:0], chunk[35:0], N[5:0], ts}
//     out_valid/out_ready/out_data window packet
//                                 {last, ts, loc_x[5:0], loc_y[5:0], K[1:0], win[8:0]}
//     cfg_err       one-cycle pulse on a bad config or chunk overflow
//     busy          high while scanning
//
//   Build option: define IFMAP_ZERO_SKIP_EN to drop all-zero windows. The
//   final location is always emitted so that last is carried.
module ifmap_window_buffer #(
  parameter int MAX_SIZE = 16,
  parameter int CHUNK_W  = 36,
  parameter int PKT_W    = 46,
  parameter int OUT_W    = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             cfg_err,
  output logic             busy
);

  localparam int BANK_W = MAX_SIZE * MAX_SIZE;
  localparam int IW     = $clog2(BANK_W);
  localparam int PW     = 12;   // wide enough for 63*63 and 15*36
  localparam int CW     = 4;    // chunk counter, saturating

  typedef enum logic {LOAD, SCAN} state_t;

  state_t            state;
  logic [BANK_W-1:0] bank [2];
  logic [CW-1:0]     cidx [2];
  logic [5:0]        n_l;
  logic [1:0]        k_l;
  logic              ts_l;
  logic [5:0]        cy, cx;
  logic              last_issued;

  // Input packet fields
  logic               in_done, in_ts;
  logic [1:0]         in_k;
  logic [5:0]         in_n;
  logic [CHUNK_W-1:0] in_chunk;

  assign in_done  = in_data[45];
  assign in_k     = in_data[44:43];
  assign in_chunk = in_data[42:7];
  assign in_n     = in_data[6:1];
  assign in_ts    = in_data[0];

  assign in_ready = (state == LOAD);
  assign busy     = (state == SCAN);

  // Chunk placement and error detection
  logic [PW-1:0]     first_pix, nsq, wr_limit;
  logic              overflow, cfg_bad;
  logic [BANK_W-1:0] wr_bank;

  assign first_pix = PW'(cidx[in_ts]) * PW'(CHUNK_W);
  assign nsq       = PW'(in_n) * PW'(in_n);
  assign wr_limit  = (nsq > PW'(BANK_W)) ? PW'(BANK_W) : nsq;
  assign overflow  = (first_pix >= nsq);
  assign cfg_bad   = (in_k == 2'd0) || ({4'd0, in_k} > in_n) || (in_n > 6'(MAX_SIZE));

  // Merge the chunk into the selected bank; pixels past min(N^2, bank size)
  // are dropped so a short last chunk never clobbers unrelated bits.
  always_comb begin
    logic [PW-1:0] p;
    p       = '0;
    wr_bank = bank[in_ts];
    for (int i = 0; i < CHUNK_W; i++) begin
      p = first_pix + PW'(i);
      if (p < wr_limit) wr_bank[p[IW-1:0]] = in_chunk[CHUNK_W-1-i];
    end
  end

  // Window extraction at the current scan location
  logic [5:0] lim;
  logic [8:0] win;
  logic       is_last, skip;

  assign lim     = n_l - {4'd0, k_l};
  assign is_last = (cy == lim) && (cx == lim);

  always_comb begin
    logic [PW-1:0]     p;
    logic [3:0]        wi;
    logic [BANK_W-1:0] rd;
    p   = '0;
    wi  = '0;
    win = '0;
    rd  = bank[ts_l];
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (2'(r) < k_l && 2'(c) < k_l) begin
          p  = (PW'(cy) + PW'(r)) * PW'(n_l) + PW'(cx) + PW'(c);
          wi = 4'd8 - (4'(r) * {2'b00, k_l} + 4'(c));
          win[wi] = rd[p[IW-1:0]];
        end
      end
    end
  end

`ifdef IFMAP_ZERO_SKIP_EN
  assign skip = (win == 9'd0) && !is_last;
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      bank[0]     <= '0;
      bank[1]     <= '0;
      cidx[0]     <= '0;
      cidx[1]     <= '0;
      n_l         <= '0;
      k_l         <= '0;
      ts_l        <= 1'b0;
      cy          <= '0;
      cx          <= '0;
      last_issued <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (!overflow) begin
              bank[in_ts] <= wr_bank;
              if (cidx[in_ts] != '1) cidx[in_ts] <= cidx[in_ts] + 1'b1;
            end
            cfg_err <= overflow | (in_done & cfg_bad);
            if (in_done) begin
              cidx[in_ts] <= '0;
              n_l         <= in_n;
              k_l         <= in_k;
              ts_l        <= in_ts;
              if (!cfg_bad) begin
                state       <= SCAN;
                cy          <= '0;
                cx          <= '0;
                last_issued <= 1'b0;
              end
            end
          end
        end
        SCAN: begin
          // Output register is free when empty or being consumed this cycle.
          if (!out_valid || out_ready) begin
            if (last_issued) begin
              out_valid <= 1'b0;
              state     <= LOAD;
            end else begin
              if (skip) begin
                out_valid <= 1'b0;
              end else begin
                out_valid <= 1'b1;
                out_data  <= {is_last, ts_l, cx, cy, k_l, win};
              end
              if (is_last)          last_issued <= 1'b1;
              else if (cx == lim) begin
                cx <= '0;
                cy <= cy + 1'b1;
              end else              cx <= cx + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
